// File: rtl/csa_conv_accumulator.sv
// rtl/csa_conv_accumulator.sv - carry-save window accumulator; CSA_CONV_ACC_SATURATE_EN clamps out_sum
module csa_conv_accumulator #(
    parameter int PW    = 21,
    parameter int KTAPS = 9,
    parameter int AW    = PW + 4,
    parameter int OW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_s,
    input  logic [PW-1:0] in_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_sum,
    output logic          out_ovf
);
    localparam int CW = $clog2(KTAPS);

    typedef enum logic [1:0] {ST_ACC, ST_RESOLVE, ST_HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tap_cnt_q, tap_cnt_d;
    logic [AW-1:0] acc_s_q, acc_s_d;
    logic [AW-1:0] acc_c_q, acc_c_d;
    logic [OW-1:0] out_sum_q, out_sum_d;
    logic          out_ovf_q, out_ovf_d;

    logic [AW-1:0] in_s_x, in_c_x;
    logic [AW-1:0] l1_s, l1_c, l2_s, l2_c;
    logic [AW-1:0] total;
    logic          total_ovf;

    // Two 3:2 levels; carries out of the top bit are dropped because the window total fits in AW
    always_comb begin
        in_s_x    = AW'(in_s);
        in_c_x    = AW'(in_c);
        l1_s      = acc_s_q ^ acc_c_q ^ in_s_x;
        l1_c      = ((acc_s_q & acc_c_q) | (acc_s_q & in_s_x) | (acc_c_q & in_s_x)) << 1;
        l2_s      = l1_s ^ l1_c ^ in_c_x;
        l2_c      = ((l1_s & l1_c) | (l1_s & in_c_x) | (l1_c & in_c_x)) << 1;
        total     = acc_s_q + acc_c_q;
        total_ovf = |total[AW-1:OW];
    end

    always_comb begin
        state_d   = state_q;
        tap_cnt_d = tap_cnt_q;
        acc_s_d   = acc_s_q;
        acc_c_d   = acc_c_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_s_d = l2_s;
                    acc_c_d = l2_c;
                    if (tap_cnt_q == CW'(KTAPS - 1)) begin
                        tap_cnt_d = '0;
                        state_d   = ST_RESOLVE;
                    end else begin
                        tap_cnt_d = tap_cnt_q + CW'(1);
                    end
                end
            end
            ST_RESOLVE: begin
                out_ovf_d = total_ovf;
`ifdef CSA_CONV_ACC_SATURATE_EN
                out_sum_d = total_ovf ? {OW{1'b1}} : total[OW-1:0];
`else
                out_sum_d = total[OW-1:0];
`endif
                acc_s_d   = '0;
                acc_c_d   = '0;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            tap_cnt_q <= '0;
            acc_s_q   <= '0;
            acc_c_q   <= '0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_cnt_q <= tap_cnt_d;
            acc_s_q   <= acc_s_d;
            acc_c_q   <= acc_c_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_sum = out_sum_q;
    assign out_ovf = out_ovf_q;

endmodule
